// File: rtl/hamming_decoder_pipe_pkg.sv
// Shared Hamming(12,8) types and helpers for the decoder pipeline and syndrome unit.
package hamming_pkg;

  localparam int DATA_W = 8;
  localparam int CODE_W = 12;
  localparam int SYN_W  = 4;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [SYN_W-1:0]  syn_t;

  // Code-bit index of data bit d0..d7 (positions 3,5,6,7,9,10,11,12).
  localparam int DATA_POS [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11};

  function automatic data_t extract_data(input code_t code);
    data_t d;
    d = '0;
    for (int i = 0; i < DATA_W; i++) begin
      d[i] = code[DATA_POS[i]];
    end
    return d;
  endfunction

endpackage

// File: rtl/hamming_decoder_pipe_if.sv
// Valid/ready codeword-in / decoded-data-out bundle of the Hamming decoder pipeline.
interface hamming_decoder_pipe_if;
  import hamming_pkg::*;

  logic  in_valid;
  logic  in_ready;
  code_t in_code;
  logic  out_valid;
  logic  out_ready;
  data_t out_data;
  syn_t  out_syndrome;
  logic  out_corr;
  logic  out_uncorr;

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_data, out_syndrome, out_corr, out_uncorr
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_data, out_syndrome, out_corr, out_uncorr
  );

endinterface

// File: rtl/hamming_decoder_pipe_syndrome.sv
// Combinational Hamming(12,8) syndrome: bit k is the XOR of all positions whose index has bit k set.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  code_t code_i,
  output syn_t  syn_o
);

  // Accumulate each code bit into every syndrome bit its position index selects.
  always_comb begin
    syn_o = '0;
    for (int i = 0; i < CODE_W; i++) begin
      for (int k = 0; k < SYN_W; k++) begin
        syn_o[k] = syn_o[k] ^ (code_i[i] & 1'((i + 1) >> k));
      end
    end
  end

endmodule

// File: rtl/hamming_decoder_pipe.sv
// Two-stage Hamming(12,8) decoder with valid/ready flow control.
// Define HAMMING_DEC_ERR_CNT_EN to add saturating corrected/uncorrectable event counters.
module hamming_decoder_pipe
  import hamming_pkg::*;
`ifdef HAMMING_DEC_ERR_CNT_EN
#(
  parameter int CNT_W = 16
)
`endif
(
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef HAMMING_DEC_ERR_CNT_EN
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       corr_cnt,
  output logic [CNT_W-1:0]       uncorr_cnt,
`endif
  hamming_decoder_pipe_if.slave  bus
);

  logic  s1_valid_q, s1_valid_d;
  code_t s1_code_q, s1_code_d;
  syn_t  s1_syn_q, s1_syn_d;
  logic  out_valid_q, out_valid_d;
  data_t out_data_q, out_data_d;
  syn_t  out_syn_q, out_syn_d;
  logic  out_corr_q, out_corr_d;
  logic  out_uncorr_q, out_uncorr_d;

  syn_t  in_syn_s;
  code_t fix_code_s;
  logic  adv2_s;
  logic  in_ready_s;
  logic  corr_s;
  logic  uncorr_s;

  hamming_syndrome u_syndrome (
    .code_i (bus.in_code),
    .syn_o  (in_syn_s)
  );

  // S1 may refill whenever it is empty or its word moves into S2 this cycle.
  assign adv2_s     = !out_valid_q || bus.out_ready;
  assign in_ready_s = !s1_valid_q || adv2_s;

  // Flip the single bit the syndrome points at; 0 and 13..15 match no position.
  always_comb begin
    fix_code_s = s1_code_q;
    for (int i = 0; i < CODE_W; i++) begin
      fix_code_s[i] = s1_code_q[i] ^ (s1_syn_q == syn_t'(i + 1));
    end
    corr_s   = (s1_syn_q != 4'd0) && (s1_syn_q <= 4'd12);
    uncorr_s = (s1_syn_q >= 4'd13);
  end

  // Stage 1 next state: capture codeword and syndrome on an input transfer.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_syn_d   = s1_syn_q;
    if (in_ready_s) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_code_d = bus.in_code;
        s1_syn_d  = in_syn_s;
      end else begin
        s1_code_d = s1_code_q;
        s1_syn_d  = s1_syn_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2 next state: outputs only change when the consumer side can advance.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_syn_d    = out_syn_q;
    out_corr_d   = out_corr_q;
    out_uncorr_d = out_uncorr_q;
    if (adv2_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d   = extract_data(fix_code_s);
        out_syn_d    = s1_syn_q;
        out_corr_d   = corr_s;
        out_uncorr_d = uncorr_s;
      end else begin
        out_data_d   = out_data_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline registers; reset discards both stages at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_code_q    <= '0;
      s1_syn_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_syn_q    <= '0;
      out_corr_q   <= 1'b0;
      out_uncorr_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_code_q    <= s1_code_d;
      s1_syn_q     <= s1_syn_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_syn_q    <= out_syn_d;
      out_corr_q   <= out_corr_d;
      out_uncorr_q <= out_uncorr_d;
    end
  end

  assign bus.in_ready     = in_ready_s;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_syndrome = out_syn_q;
  assign bus.out_corr     = out_corr_q;
  assign bus.out_uncorr   = out_uncorr_q;

`ifdef HAMMING_DEC_ERR_CNT_EN
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;
  logic             out_xfer_s;

  assign out_xfer_s = out_valid_q && bus.out_ready;

  // Counters saturate at all-ones; a clear beats a same-cycle increment.
  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else begin
      if (out_xfer_s && out_corr_q && (corr_cnt_q != {CNT_W{1'b1}})) begin
        corr_cnt_d = corr_cnt_q + CNT_W'(1'b1);
      end else begin
        corr_cnt_d = corr_cnt_q;
      end
      if (out_xfer_s && out_uncorr_q && (uncorr_cnt_q != {CNT_W{1'b1}})) begin
        uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1'b1);
      end else begin
        uncorr_cnt_d = uncorr_cnt_q;
      end
    end
  end

  // Error event counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;
`endif

endmodule

// File: tb/tb_hamming_decoder_pipe.sv
// Self-checking bench for hamming_decoder_pipe: position-arithmetic reference model plus directed vectors.
module tb_hamming_decoder_pipe;
  import hamming_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] syn;
    logic       corr;
    logic       uncorr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  logic [11:0] stim_q[$];
  logic held = 1'b0;
  exp_t held_v;

  hamming_decoder_pipe_if bus();

`ifdef HAMMING_DEC_ERR_CNT_EN
  logic        cnt_clr;
  logic [15:0] corr_cnt;
  logic [15:0] uncorr_cnt;
`endif

  hamming_decoder_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef HAMMING_DEC_ERR_CNT_EN
    .cnt_clr    (cnt_clr),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference decode: syndrome is the XOR of the indices of all set positions.
  function automatic exp_t model(input logic [11:0] c);
    exp_t e;
    int s;
    logic [11:0] fixed;
    int dpos [8];
    dpos = '{3, 5, 6, 7, 9, 10, 11, 12};
    s = 0;
    fixed = c;
    for (int p = 1; p <= 12; p++) if (c[p-1]) s = s ^ p;
    e.syn = 4'(s);
    e.corr = (s >= 1) && (s <= 12);
    e.uncorr = (s >= 13);
    if (e.corr) fixed[s-1] = ~fixed[s-1];
    for (int i = 0; i < 8; i++) e.data[i] = fixed[dpos[i]-1];
    return e;
  endfunction

  function automatic exp_t dut_out();
    exp_t e;
    e.data = bus.out_data;
    e.syn = bus.out_syndrome;
    e.corr = bus.out_corr;
    e.uncorr = bus.out_uncorr;
    return e;
  endfunction

  // Scoreboard: record input transfers, check every output transfer and held outputs.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (held) check("hold_stable", 32'(dut_out()), 32'(held_v));
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.in_code));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(1), 32'(0));
        end else begin
          check("out_fields", 32'(dut_out()), 32'(exp_q.pop_front()));
        end
      end
      held = bus.out_valid && !bus.out_ready;
      held_v = dut_out();
    end
  end

  task automatic drive_stream(input int stall_from, input int stall_len, output int ncyc);
    int cyc;
    int n_acc;
    logic acc;
    cyc = 0;
    n_acc = 0;
    while (stim_q.size() > 0 && cyc < 200) begin
      bus.in_valid = 1'b1;
      bus.in_code = stim_q[0];
      bus.out_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (stall_len > 0 && cyc == stall_from + stall_len - 1) begin
        check("stall_in_ready", 32'(bus.in_ready), 32'(0));
        check("stall_accepts", 32'(n_acc), 32'(2));
      end
      @(posedge clk);
      #1;
      if (acc) begin
        void'(stim_q.pop_front());
        n_acc++;
      end
      cyc++;
    end
    if (cyc >= 200) check("stream_timeout", 32'(1), 32'(0));
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    ncyc = cyc;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'(0));
  endtask

  logic [11:0] lit_code [7];
  exp_t        lit_exp  [7];
  int          ncyc;

  initial begin
    lit_code = '{12'h000, 12'hA58, 12'hA48, 12'hA59, 12'hA68, 12'hA98, 12'h259};
    lit_exp  = '{{8'h00, 4'h0, 1'b0, 1'b0},
                 {8'hAA, 4'h0, 1'b0, 1'b0},
                 {8'hAA, 4'h5, 1'b1, 1'b0},
                 {8'hAA, 4'h1, 1'b1, 1'b0},
                 {8'hAD, 4'h3, 1'b1, 1'b0},
                 {8'hA2, 4'hF, 1'b0, 1'b1},
                 {8'h2A, 4'hD, 1'b0, 1'b1}};
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_code = 12'h000;
    bus.out_ready = 1'b1;
`ifdef HAMMING_DEC_ERR_CNT_EN
    cnt_clr = 1'b0;
`endif

    for (int i = 0; i < 7; i++) check("model_literal", 32'(model(lit_code[i])), 32'(lit_exp[i]));

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_in_ready", 32'(bus.in_ready), 32'(1));
    check("rst_out_fields", 32'(dut_out()), 32'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: out_valid appears two cycles after the accepting cycle.
    bus.in_valid = 1'b1;
    bus.in_code = 12'h000;
    @(negedge clk);
    check("lat_accept", 32'(bus.in_ready), 32'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1", 32'(bus.out_valid), 32'(0));
    @(negedge clk);
    check("lat_cycle2", 32'(bus.out_valid), 32'(1));
    @(posedge clk);
    #1;
    drain();

    // Back-to-back directed vectors at full throughput.
    for (int i = 1; i < 7; i++) stim_q.push_back(lit_code[i]);
    drive_stream(0, 0, ncyc);
    check("throughput_cycles", 32'(ncyc), 32'(6));
    drain();

    // Downstream stall of 5 cycles in the middle of 4 codewords.
    stim_q = '{12'hA58, 12'hA48, 12'h259, 12'hA68};
    drive_stream(1, 5, ncyc);
    drain();

    // Async reset with both stages full.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_code = 12'hA58;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check("full_out_valid", 32'(bus.out_valid), 32'(1));
    check("full_in_ready", 32'(bus.in_ready), 32'(0));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'(0));
    check("midrst_in_ready", 32'(bus.in_ready), 32'(1));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", 32'(bus.out_valid), 32'(0));
    end
    @(posedge clk);
    #1;

`ifdef HAMMING_DEC_ERR_CNT_EN
    stim_q = '{12'hA48, 12'hA59, 12'hA68};
    drive_stream(0, 0, ncyc);
    drain();
    @(posedge clk);
    #1;
    check("corr_cnt", 32'(corr_cnt), 32'(3));
    check("uncorr_cnt", 32'(uncorr_cnt), 32'(0));
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    check("corr_cnt_clr", 32'(corr_cnt), 32'(0));
`endif

    check("leftover", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
